// File: rtl/mat_vec_engine_pkg.sv
// -----------------------------------------------------------------------------
// mat_vec_pkg
// Shared definitions for the matrix-vector engine: default geometry constants
// and the FSM state encoding. The encoding is visible on the `state` output
// (LEDR display), so the numeric values are fixed and must not change.
// -----------------------------------------------------------------------------
package mat_vec_pkg;

  localparam int DEF_ROWS   = 8;
  localparam int DEF_COLS   = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 24;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DONE    = 3'd3
  } state_t;

endpackage

// File: rtl/mat_vec_engine_if.sv
// -----------------------------------------------------------------------------
// mat_vec_engine_if
// Bundles the command, beat-stream and result signals of mat_vec_engine.
//   start/acc_mode          : operation request (acc_mode sampled with start)
//   in_valid/in_ready       : beat handshake
//   in_a (ROWS*DATA_W)      : one column of A, row i at [i*DATA_W +: DATA_W]
//   in_b (DATA_W)           : matching vector element
//   res_valid/res_ready     : result handshake
//   result (ROWS*ACC_W)     : row accumulators, row i at [i*ACC_W +: ACC_W]
//   overflow (ROWS)         : sticky per-row carry-out flags
// master = producer/consumer side (testbench or host), slave = the engine.
// -----------------------------------------------------------------------------
interface mat_vec_engine_if
  import mat_vec_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
);

  logic                    start;
  logic                    acc_mode;
  logic                    in_valid;
  logic                    in_ready;
  logic [ROWS*DATA_W-1:0]  in_a;
  logic [DATA_W-1:0]       in_b;
  logic                    res_valid;
  logic                    res_ready;
  logic [ROWS*ACC_W-1:0]   result;
  logic [ROWS-1:0]         overflow;

  modport master (
    output start, acc_mode, in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, result, overflow
  );

  modport slave (
    input  start, acc_mode, in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, result, overflow
  );

endinterface

// File: rtl/mat_vec_engine_mac_lane.sv
// -----------------------------------------------------------------------------
// mac_lane
// One row of the engine: a product register followed by an accumulator.
//   clk, rst     : clock and synchronous active-high reset
//   i_clear      : clear accumulator and overflow flag
//   i_load       : capture i_a*i_b into the product register this edge
//   i_a, i_b     : unsigned operands
//   o_acc        : accumulator value (wraps modulo 2^ACC_W)
//   o_overflow   : sticky carry-out of the accumulator
// A product captured at edge N is added at edge N+1; r_add_pending tracks
// that a fresh product is waiting, so stalls in the beat stream never cause
// a product to be added twice or skipped.
// -----------------------------------------------------------------------------
module mac_lane #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [ACC_W-1:0]  o_acc,
  output logic              o_overflow
);

  localparam int PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] r_prod;
  logic              r_add_pending;
  logic [ACC_W-1:0]  r_acc;
  logic              r_overflow;

  logic [PROD_W-1:0] w_prod;
  logic [ACC_W:0]    w_sum;

  // Operands widened first so the multiply is evaluated at full product width.
  assign w_prod = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};

  // One extra bit on the left captures the carry-out used for overflow.
  assign w_sum = {1'b0, r_acc} + {{(ACC_W - PROD_W + 1){1'b0}}, r_prod};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod        <= '0;
      r_add_pending <= 1'b0;
      r_acc         <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (i_load) begin
        r_prod <= w_prod;
      end
      r_add_pending <= i_load;

      // Clear wins: it only happens on a start from IDLE, when no product
      // can still be pending, but priority keeps the behaviour well defined.
      if (i_clear) begin
        r_acc      <= '0;
        r_overflow <= 1'b0;
      end else if (r_add_pending) begin
        r_acc <= w_sum[ACC_W-1:0];
        if (w_sum[ACC_W]) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  assign o_acc      = r_acc;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/mat_vec_engine.sv
// -----------------------------------------------------------------------------
// mat_vec_engine
// Streams COLS beats (one column of A plus one element of b per beat) and
// accumulates A*b into ROWS parallel MAC lanes.
//   clk, rst : clock and synchronous active-high reset (reset has priority)
//   bus      : mat_vec_engine_if slave port (command, beats, results)
//   state    : current FSM encoding (IDLE=0 FETCH=1 COMPUTE=2 DONE=3)
// Flow: IDLE --start--> FETCH --COLS beats--> COMPUTE --> DONE --res_ready--> IDLE
// COMPUTE exists so that the add of the final product lands before DONE,
// giving res_valid two cycles after the edge that took the last beat.
// -----------------------------------------------------------------------------
module mat_vec_engine
  import mat_vec_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  mat_vec_engine_if.slave  bus,
  output logic [2:0]       state
);

  localparam int CNT_W = $clog2(COLS + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_beat_cnt;

  logic w_start_accept;
  logic w_clear;
  logic w_beat_accept;
  logic w_last_beat;

  // Start is only honoured in IDLE; anywhere else it is ignored entirely,
  // including its clearing side effect.
  assign w_start_accept = (r_state == ST_IDLE) && bus.start;
  assign w_clear        = w_start_accept && !bus.acc_mode;
  assign w_beat_accept  = (r_state == ST_FETCH) && bus.in_valid;
  assign w_last_beat    = (r_beat_cnt == CNT_W'(COLS - 1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (w_beat_accept && w_last_beat) begin
          w_state_next = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        w_state_next = ST_DONE;
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Beat counter: zeroed on every FETCH entry, advances only on acceptance
  // so in_valid gaps never lose or duplicate a beat.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= '0;
    end else if (w_start_accept) begin
      r_beat_cnt <= '0;
    end else if (w_beat_accept) begin
      r_beat_cnt <= r_beat_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // MAC lanes, one per output row
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] w_lane_acc [ROWS];
  logic [ROWS-1:0]  w_lane_ovf;

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_lane
      mac_lane #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_lane (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_load     (w_beat_accept),
        .i_a        (bus.in_a[gi*DATA_W +: DATA_W]),
        .i_b        (bus.in_b),
        .o_acc      (w_lane_acc[gi]),
        .o_overflow (w_lane_ovf[gi])
      );

      assign bus.result[gi*ACC_W +: ACC_W] = w_lane_acc[gi];
    end
  endgenerate

  assign bus.overflow  = w_lane_ovf;
  assign bus.in_ready  = (r_state == ST_FETCH);
  assign bus.res_valid = (r_state == ST_DONE);
  assign state         = r_state;

endmodule

// File: doc/mat_vec_engine.md
MAT_VEC_ENGINE -- requirements
Module: mat_vec_engine

Interface
REQ-001 Parameter ROWS, default 8: number of output rows and parallel MAC lanes (≥1).
REQ-002 Parameter COLS, default 8: vector length and beats per operation (≥2).
REQ-003 Parameter DATA_W, default 8: unsigned operand width.
REQ-004 Parameter ACC_W, default 24: accumulator width (≥2*DATA_W).
REQ-005 clk  input  1: single clock; all state changes on its rising edge.
REQ-006 rst  input  1: synchronous, active-high reset.
REQ-007 start  input  1: single-cycle request to begin an operation.
REQ-008 acc_mode  input  1: sampled with start; 1 means keep previous accumulators, 0 means clear them.
REQ-009 in_valid  input  1: beat valid.
REQ-010 in_ready  output  1: engine accepts a beat.
REQ-011 in_a  input  ROWS*DATA_W: column j of matrix A, row i at bits [i*DATA_W +: DATA_W].
REQ-012 in_b  input  DATA_W: vector element j.
REQ-013 res_valid  output  1: results stable and valid.
REQ-014 res_ready  input  1: consumer acknowledges results.
REQ-015 result  output  ROWS*ACC_W: accumulator of row i at bits [i*ACC_W +: ACC_W].
REQ-016 overflow  output  ROWS: sticky per-row accumulator carry-out flag.
REQ-017 state  output  3: current FSM encoding, for LEDR display.

Function
REQ-018 FSM states SHALL be IDLE=0, FETCH=1, COMPUTE=2, DONE=3.
REQ-019 IDLE->FETCH on start; start in any other state SHALL be ignored.
REQ-020 On an accepted start with acc_mode=0, all accumulators and overflow bits SHALL clear at the same edge; with acc_mode=1 they SHALL be retained.
REQ-021 in_ready SHALL be 1 exactly while state==FETCH.
REQ-022 A beat SHALL be accepted on an edge where in_valid && in_ready; the beat counter advances only on acceptance, so stalls (in_valid=0) are lossless.
REQ-023 Each accepted beat SHALL load per-row product in_a[i]*in_b, full 2*DATA_W width, into a product register at that edge.
REQ-024 Each loaded product SHALL be zero-extended to ACC_W and added to its row accumulator at the following edge.
REQ-025 Accumulation SHALL wrap modulo 2^ACC_W; any carry out SHALL set overflow[i], held until cleared by reset or an acc_mode=0 start.
REQ-026 Acceptance of the COLS-th beat SHALL move FETCH->COMPUTE at that edge; COMPUTE->DONE unconditionally at the next edge, when the last add completes.
REQ-027 res_valid SHALL be 1 exactly while state==DONE; result and overflow SHALL be stable throughout DONE.
REQ-028 DONE->IDLE when res_ready=1; result SHALL hold its value in IDLE.
REQ-029 Latency: the first res_valid cycle SHALL be 2 cycles after the edge that accepted the last beat.
REQ-030 Beat counter width SHALL be $clog2(COLS+1); the counter SHALL reset to 0 on every FETCH entry.

Reset
REQ-031 rst SHALL have priority over all other inputs and take effect at the next edge in any state, including mid-FETCH.
REQ-032 After reset: state=IDLE(0), in_ready=0, res_valid=0, result=0, overflow=0, product registers=0, beat counter=0.

Structure
REQ-033 Package mat_vec_pkg SHALL hold the state enum with the fixed encodings and the default parameter constants.
REQ-034 Sub-module mac_lane (product register, accumulator, overflow bit, clear/enable inputs) SHALL be instantiated ROWS times by a generate loop.

Verification
REQ-035 Defaults; A all 1, B=1..8, acc_mode=0 -> every row 0x000024 and overflow=0; res_valid 2 cycles after the 8th beat.
REQ-036 Repeat the REQ-035 run with acc_mode=1 -> every row 0x000048; then run with acc_mode=0 -> 0x000024.
REQ-037 ACC_W=16; A=B=0xFF for all beats -> every row 0xF008 and overflow all 1.
REQ-038 REQ-035 stimulus with in_valid deasserted every other cycle -> identical results; 8 beats accepted over 15 cycles.
REQ-039 rst pulsed after 3 accepted beats -> state=0, result=0, in_ready=0 on the next cycle; a following clean run gives 0x000024.
REQ-040 start pulsed during FETCH and during DONE -> no state change and no accumulator clear; res_ready held 0 keeps DONE indefinitely.
